ifu_prefetch: RTL

- Instruction-fetch front end that produces the instruction stream the core's opcode decoder consumes.
- Issues word fetches to instruction memory over a req/gnt/rvalid interface and buffers returned words with their PCs in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Handles branch/jump redirects from execute: flushes the FIFO and discards in-flight responses.

---
 rtl/core_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/ifu_prefetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: canonical NOP, fetch FSM state encoding and the
// major-opcode type used by the decoder.
package core_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } ifu_state_e;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  // A 32-bit encoding always has both low bits set.
  function automatic logic is_rv32_word(input logic [31:0] w);
    return (w[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush. Push while full is accepted only when a pop
// happens in the same cycle. No read bypass: data_o is the registered head.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: one-outstanding word fetcher feeding a small
// {pc, inst} FIFO that the decoder drains via valid/ready.
// Optional build macro: IFU_ILLEGAL_CHECK_EN adds inst_illegal_o and replaces
// non-32-bit encodings at the head with NOP.
//
// state  | meaning
// IDLE   | FIFO has no slot for another fetch
// REQ    | request asserted, waiting for grant
// WAIT   | granted, waiting for rvalid (kill drops that response)
module ifu_prefetch
  import core_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
`ifdef IFU_ILLEGAL_CHECK_EN
  ,
  output logic        inst_illegal_o
`endif
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifu_state_e  state_q, state_d;
  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;

  logic        push, pop;
  logic [63:0] head;
  logic        fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, count_next;
  logic        slot_free_now, slot_free_next;
  logic        unused_pc_bits;

  // Byte-offset bits of the redirect target are ignored.
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // A redirect discards anything that would enter or leave the FIFO this cycle.
  assign push = (state_q == S_WAIT) & imem_rvalid_i & ~kill_q & ~redirect_i;
  assign pop  = inst_valid_o & inst_ready_i & ~redirect_i;

  assign count_next     = fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign slot_free_now  = (fifo_count < DEPTH_C);
  assign slot_free_next = (count_next < DEPTH_C);

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  ({fetch_pc_q - 30'd1, 2'b00, imem_rdata_i}),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: a fetch is only started when its slot is already reserved.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (redirect_i || slot_free_now) state_d = S_REQ;
      S_REQ:  if (imem_gnt_i) state_d = S_WAIT;
      S_WAIT: if (imem_rvalid_i) state_d = (redirect_i || slot_free_next) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the address is held stable by fetch_pc until granted or redirected.
  always_comb begin
    imem_req_o  = (state_q == S_REQ);
    imem_addr_o = {fetch_pc_q, 2'b00};
  end

  // Fetch PC and kill flag: kill marks the single in-flight response as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if (redirect_i) fetch_pc_d = redirect_pc_i[31:2];
    else if (state_q == S_REQ && imem_gnt_i) fetch_pc_d = fetch_pc_q + 30'd1;
    if (state_q == S_WAIT && imem_rvalid_i) kill_d = 1'b0;
    else if (redirect_i && ((state_q == S_REQ && imem_gnt_i) || state_q == S_WAIT)) kill_d = 1'b1;
  end

  // Fetch PC and kill registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC[31:2];
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
    end
  end

  assign inst_valid_o = ~fifo_empty;

  // Head presentation: NOP and PC 0 while empty, registered entry otherwise.
  always_comb begin
    inst_o    = NOP_INST;
    inst_pc_o = '0;
    if (!fifo_empty) begin
      inst_o    = head[31:0];
      inst_pc_o = head[63:32];
`ifdef IFU_ILLEGAL_CHECK_EN
      if (!is_rv32_word(head[31:0])) inst_o = NOP_INST;
`endif
    end
  end

`ifdef IFU_ILLEGAL_CHECK_EN
  assign inst_illegal_o = ~fifo_empty & ~is_rv32_word(head[31:0]);
`endif

endmodule
